// File: rtl/mcs8_pkg.sv
// Shared widths and types for the mcs8 instruction-fetch path.
package mcs8_pkg;

  localparam int ADDR_W = 14;
  localparam int DAT_W  = 8;
  localparam int STAT_W = 16;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DAT_W-1:0]  byte_t;

endpackage

// File: rtl/ifq_fifo.sv
// Small register-based FIFO holding {byte, address} fetch entries.
// The head entry is read straight from storage registers; flush empties the queue in one edge.
module ifq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 22
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   push,
  input  logic [W-1:0]           pushData,
  input  logic                   pop,
  input  logic                   flush,
  output logic [W-1:0]           headData,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wrPtrReg;
  logic [PTR_W-1:0] rdPtrReg;
  logic [PTR_W:0]   countReg;
  logic             doPush;
  logic             doPop;
  logic [W-1:0]     mem [DEPTH];

  // Flush wins over any same-edge push or pop.
  assign doPush = push & ~flush;
  assign doPop  = pop & ~flush & (countReg != '0);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gEntry
      always_ff @(posedge clk) begin
        if (srst) begin
          mem[gi] <= '0;
        end else if (doPush && (wrPtrReg == PTR_W'(gi))) begin
          mem[gi] <= pushData;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (srst || flush) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
    end else begin
      if (doPush) begin
        wrPtrReg <= wrPtrReg + PTR_W'(1);
      end
      if (doPop) begin
        rdPtrReg <= rdPtrReg + PTR_W'(1);
      end
      case ({doPush, doPop})
        2'b10:   countReg <= countReg + (PTR_W+1)'(1);
        2'b01:   countReg <= countReg - (PTR_W+1)'(1);
        default: countReg <= countReg;
      endcase
    end
  end

  assign headData = mem[rdPtrReg];
  assign count    = countReg;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: issues ROM reads ahead of the CPU and queues bytes with their PCs.
// Optional statistics counters are enabled by defining IFETCH_QUEUE_STAT_EN.
module ifetch_queue #(
  parameter int          DEPTH  = 4,
  parameter int          ADDR_W = mcs8_pkg::ADDR_W,
  parameter int          DAT_W  = mcs8_pkg::DAT_W,
  parameter int unsigned RST_PC = 0
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  output logic [ADDR_W-1:0] I_ADDR_O,
  output logic              I_RD_O,
  input  logic [DAT_W-1:0]  I_DAT_I,
  output logic [DAT_W-1:0]  Q_DAT_O,
  output logic [ADDR_W-1:0] Q_PC_O,
  output logic              Q_VLD_O,
  input  logic              Q_RDY_I,
  input  logic              JMP_I,
  input  logic [ADDR_W-1:0] JMP_ADDR_I
`ifdef IFETCH_QUEUE_STAT_EN
  ,
  output logic [mcs8_pkg::STAT_W-1:0] STAT_FETCH_O,
  output logic [mcs8_pkg::STAT_W-1:0] STAT_DROP_O
`else
`endif
);

  import mcs8_pkg::*;

  localparam int                CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] RST_ADDR = ADDR_W'(RST_PC);

  logic [ADDR_W-1:0]       fpcReg;
  logic [ADDR_W-1:0]       fpcNext;
  logic [ADDR_W-1:0]       inflightAddrReg;
  logic                    inflightReg;
  logic [CNT_W-1:0]        fifoCount;
  logic [CNT_W:0]          used;
  logic                    issue;
  logic                    push;
  logic                    pop;
  logic [DAT_W+ADDR_W-1:0] headData;

  // Credit counts queued plus in-flight entries and ignores a same-cycle pop, so a full queue never overflows.
  assign used  = {1'b0, fifoCount} + (CNT_W+1)'(inflightReg);
  assign issue = ~RST_I & ~JMP_I & (used < (CNT_W+1)'(DEPTH));
  assign push  = inflightReg & ~JMP_I;
  assign pop   = Q_VLD_O & Q_RDY_I & ~JMP_I;

  always_comb begin
    fpcNext = fpcReg;
    if (JMP_I) begin
      fpcNext = JMP_ADDR_I;
    end else if (issue) begin
      fpcNext = fpcReg + ADDR_W'(1);
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      fpcReg          <= RST_ADDR;
      inflightReg     <= 1'b0;
      inflightAddrReg <= '0;
    end else begin
      fpcReg      <= fpcNext;
      inflightReg <= issue;
      if (issue) begin
        inflightAddrReg <= fpcReg;
      end
    end
  end

  ifq_fifo #(
    .DEPTH (DEPTH),
    .W     (DAT_W + ADDR_W)
  ) uFifo (
    .clk      (CLK_I),
    .srst     (RST_I),
    .push     (push),
    .pushData ({I_DAT_I, inflightAddrReg}),
    .pop      (pop),
    .flush    (JMP_I),
    .headData (headData),
    .count    (fifoCount)
  );

  assign I_ADDR_O = fpcReg;
  assign I_RD_O   = issue;
  assign Q_VLD_O  = (fifoCount != '0);
  assign Q_DAT_O  = headData[DAT_W+ADDR_W-1:ADDR_W];
  assign Q_PC_O   = headData[ADDR_W-1:0];

`ifdef IFETCH_QUEUE_STAT_EN
  logic [STAT_W-1:0] statFetchReg;
  logic [STAT_W-1:0] statDropReg;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      statFetchReg <= '0;
      statDropReg  <= '0;
    end else begin
      if (push) begin
        statFetchReg <= statFetchReg + STAT_W'(1);
      end
      if (JMP_I && inflightReg) begin
        statDropReg <= statDropReg + STAT_W'(1);
      end
    end
  end

  assign STAT_FETCH_O = statFetchReg;
  assign STAT_DROP_O  = statDropReg;
`else
`endif

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 The block SHALL take these parameters, one per line: name, default, meaning.
- DEPTH, 4, queue entries (power of two, 2..16)
- ADDR_W, 14, instruction address width
- DAT_W, 8, instruction byte width
- RST_PC, 0, fetch address after reset
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- CLK_I  in  1  single clock, rising edge
- RST_I  in  1  reset, synchronous, active-high
- I_ADDR_O  out  ADDR_W  ROM byte address
- I_RD_O  out  1  read issued this cycle
- I_DAT_I  in  DAT_W  ROM data, valid the cycle after issue
- Q_DAT_O  out  DAT_W  head byte to CPU
- Q_PC_O  out  ADDR_W  address of head byte
- Q_VLD_O  out  1  head valid
- Q_RDY_I  in  1  CPU pops head when Q_VLD_O=1
- JMP_I  in  1  redirect pulse
- JMP_ADDR_I  in  ADDR_W  redirect target

Function
REQ-003 The block SHALL keep a fetch pointer fpc; I_ADDR_O SHALL equal fpc combinationally.
REQ-004 I_RD_O SHALL be 1 iff count + inflight < DEPTH and JMP_I=0; on issue, fpc increments by 1 modulo 2^ADDR_W (0x3FFF -> 0x0000).
REQ-005 A one-bit inflight flag and its address SHALL be registered on issue; next cycle I_DAT_I SHALL be pushed with that address.
REQ-006 Issue credit SHALL ignore a same-cycle pop (conservative); the queue SHALL never overflow.
REQ-007 Pop occurs when Q_VLD_O & Q_RDY_I; simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-008 Q_VLD_O = (count != 0); Q_DAT_O/Q_PC_O come from registered head storage, no combinational I_DAT_I-to-Q path.
REQ-009 JMP_I=1 SHALL, at that edge: clear count, drop inflight data, ignore pop, load fpc <= JMP_ADDR_I.
REQ-010 Redirect latency: JMP_I at edge N -> I_ADDR_O=target in cycle N..N+1, I_RD_O=1 -> Q_VLD_O=1 after edge N+2, Q_PC_O=target.
REQ-011 Q_RDY_I with Q_VLD_O=0 SHALL be ignored.

Reset
REQ-012 RST_I=1 at a rising edge SHALL set fpc=RST_PC, count=0, inflight=0, head storage=0; hence Q_VLD_O=0, Q_DAT_O=0, Q_PC_O=0, I_ADDR_O=RST_PC.
REQ-013 Reset SHALL override JMP_I and pops; a read in flight at reset SHALL be discarded.
REQ-014 First issue SHALL occur in the first cycle with RST_I=0.

Configuration
REQ-015 Macro IFETCH_QUEUE_STAT_EN: when defined, add outputs STAT_FETCH_O[15:0] (count of pushes) and STAT_DROP_O[15:0] (count of inflight reads dropped by JMP_I); both wrap at 0xFFFF and reset to 0.
REQ-016 Without IFETCH_QUEUE_STAT_EN, these ports and counters SHALL not exist; other behaviour identical.

Structure
REQ-017 Package mcs8_pkg SHALL hold ADDR_W=14, DAT_W=8, and typedefs addr_t, byte_t.
REQ-018 Storage SHALL be sub-module ifq_fifo (DEPTH x (DAT_W+ADDR_W), push/pop/flush, count); fetch control stays in ifetch_queue.

Verification
REQ-019 Reset, ROM byte=addr[7:0], Q_RDY_I=1 -> Q_PC_O 0,1,2,... one per cycle after ramp-up; Q_DAT_O=Q_PC_O[7:0].
REQ-020 Q_RDY_I=0 for 10 cycles -> count reaches 4, I_RD_O=0, fpc=4; release -> bytes 0..3 then 4, no loss.
REQ-021 JMP_I with JMP_ADDR_I=0x0100 while inflight -> stale byte dropped, Q_VLD_O=1 after 2 edges with Q_PC_O=0x0100.
REQ-022 JMP_ADDR_I=0x3FFE -> Q_PC_O 0x3FFE, 0x3FFF, 0x0000, 0x0001.
REQ-023 RST_I asserted mid-stream with full queue -> next cycle Q_VLD_O=0, I_ADDR_O=RST_PC; stream restarts at RST_PC.
REQ-024 With IFETCH_QUEUE_STAT_EN, three redirects each with inflight -> STAT_DROP_O=3; STAT_FETCH_O equals push count.
